// File: rtl/microwave_ctrl.sv
// Microwave-oven controller: keypad M:ST entry, start/stop/door interlock, 1 s countdown, 7-seg drive.
// Latency: state, time and mag_on update one clock after the qualifying input; segments follow digits combinationally.
// No flow control: panel inputs are level-sampled every clock, and a key press is one 0->non-zero keypad transition.
module microwave_ctrl #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    input  logic [9:0] keypad,
    output logic [6:0] sec_ones_seg,
    output logic [6:0] sec_tens_seg,
    output logic [6:0] mins_seg,
    output logic       mag_on
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COOK  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    mins_q, mins_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [9:0]    key_prev_q, key_prev_d;
    logic          mag_on_q, mag_on_d;

    logic key_press;
    logic time_zero;
    logic last_sec;

    // Highest set key index wins when several keys are down together.
    function automatic logic [3:0] key_digit(input logic [9:0] k);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) d = 4'(i);
        end
        return d;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d    = state_q;
        mins_d     = mins_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        presc_d    = presc_q;
        key_prev_d = keypad;

        key_press = (key_prev_q == 10'd0) && (keypad != 10'd0);
        time_zero = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
        last_sec  = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);

        case (state_q)
            ST_COOK: begin
                // Door/stop outrank the tick: prescaler and time freeze in place.
                if (!door_closed || !stopn) begin
                    state_d = ST_PAUSE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (ones_q != 4'd0) begin
                        ones_d = ones_q - 4'd1;
                    end else if (tens_q != 4'd0) begin
                        tens_d = tens_q - 4'd1;
                        ones_d = 4'd9;
                    end else if (mins_q != 4'd0) begin
                        mins_d = mins_q - 4'd1;
                        tens_d = 4'd5;
                        ones_d = 4'd9;
                    end
                    if (last_sec) state_d = ST_IDLE;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: begin
                if (!startn && stopn && door_closed && !time_zero) begin
                    state_d = ST_COOK;
                    presc_d = '0;
                end else if (key_press) begin
                    mins_d = tens_q;
                    tens_d = ones_q;
                    ones_d = key_digit(keypad);
                end
            end
        endcase

        mag_on_d = (state_d == ST_COOK);
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state_q    <= ST_IDLE;
            mins_q     <= 4'd0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            presc_q    <= '0;
            key_prev_q <= 10'd0;
            mag_on_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mins_q     <= mins_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            presc_q    <= presc_d;
            key_prev_q <= key_prev_d;
            mag_on_q   <= mag_on_d;
        end
    end

    assign mins_seg     = seg7(mins_q);
    assign sec_tens_seg = seg7(tens_q);
    assign sec_ones_seg = seg7(ones_q);
    assign mag_on       = mag_on_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Bench for microwave_ctrl: directed oven scenarios plus random panel activity,
// every cycle compared with a digit-level behavioural model of the oven.
module tb_microwave_ctrl;

    localparam int TPS = 100;

    logic       clock = 1'b0;
    logic       clearn = 1'b0;
    logic       startn = 1'b1;
    logic       stopn = 1'b1;
    logic       door_closed = 1'b1;
    logic [9:0] keypad = 10'd0;
    logic [6:0] sec_ones_seg, sec_tens_seg, mins_seg;
    logic       mag_on;

    int total = 0;
    int bad = 0;

    microwave_ctrl #(.TICKS_PER_SEC(TPS)) dut (
        .clock(clock),
        .clearn(clearn),
        .startn(startn),
        .stopn(stopn),
        .door_closed(door_closed),
        .keypad(keypad),
        .sec_ones_seg(sec_ones_seg),
        .sec_tens_seg(sec_tens_seg),
        .mins_seg(mins_seg),
        .mag_on(mag_on)
    );

    always #5 clock = ~clock;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Model: oven time as three displayed digits, cooking flag, cycles into current second.
    int         m_min, m_ten, m_one;
    bit         m_cook;
    int         m_cnt;
    logic [9:0] m_prev;

    function automatic logic [31:0] mk(input int mi, input int te, input int on, input bit mg);
        return {10'd0, seg_tab[mi], seg_tab[te], seg_tab[on], mg};
    endfunction

    function automatic logic [31:0] dut_out();
        return {10'd0, mins_seg, sec_tens_seg, sec_ones_seg, mag_on};
    endfunction

    function automatic logic [31:0] exp_out();
        return mk(m_min, m_ten, m_one, m_cook);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_min = 0; m_ten = 0; m_one = 0;
        m_cook = 0; m_cnt = 0; m_prev = 10'd0;
    endtask

    task automatic model_edge();
        int  secs;
        int  dig;
        bit  pressed;
        secs    = m_min * 100 + m_ten * 10 + m_one;
        pressed = (m_prev == 10'd0) && (keypad != 10'd0);
        if (m_cook) begin
            if (!door_closed || !stopn) begin
                m_cook = 0;
            end else if (m_cnt + 1 == TPS) begin
                m_cnt = 0;
                if (m_one > 0) m_one--;
                else if (m_ten > 0) begin m_ten--; m_one = 9; end
                else begin m_min--; m_ten = 5; m_one = 9; end
                if (m_min + m_ten + m_one == 0) m_cook = 0;
            end else begin
                m_cnt++;
            end
        end else if (!startn && stopn && door_closed && secs != 0) begin
            m_cook = 1;
            m_cnt  = 0;
        end else if (pressed) begin
            dig = 0;
            for (int i = 9; i >= 0; i--) begin
                if (keypad[i]) begin dig = i; break; end
            end
            m_min = m_ten; m_ten = m_one; m_one = dig;
        end
        m_prev = keypad;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            if (!clearn) model_reset();
            else model_edge();
            @(negedge clock);
            check("cycle", dut_out(), exp_out());
        end
    endtask

    task automatic press(input int k, input int hold);
        keypad = 10'(1 << k);
        cyc(hold);
        keypad = 10'd0;
        cyc(1);
    endtask

    task automatic enter3(input int a, input int b, input int c);
        press(a, 2); press(b, 3); press(c, 1);
    endtask

    task automatic start_pulse();
        startn = 1'b0;
        cyc(1);
        startn = 1'b1;
    endtask

    task automatic do_clear();
        clearn = 1'b0;
        #1;
        model_reset();
        check("clear_async", dut_out(), mk(0, 0, 0, 0));
        cyc(2);
        clearn = 1'b1;
        cyc(1);
    endtask

    // n0 = clock edges already seen since cooking began; exp_n = edges at which it must stop.
    task automatic finish_cook(input string tag, input int n0, input int exp_n);
        int n;
        n = n0;
        while (mag_on === 1'b1 && n < exp_n + 1000) begin
            cyc(1);
            n++;
        end
        check(tag, n, exp_n);
        check({tag, "_end"}, dut_out(), mk(0, 0, 0, 0));
    endtask

    initial begin
        model_reset();
        #2;
        check("reset", dut_out(), mk(0, 0, 0, 0));
        cyc(2);
        clearn = 1'b1;
        cyc(2);

        // 1: door interlock, then a full 3:59 cook
        door_closed = 1'b0;
        enter3(3, 5, 9);
        check("t1_entry", dut_out(), mk(3, 5, 9, 0));
        start_pulse();
        cyc(1);
        check("t1_door_open", dut_out(), mk(3, 5, 9, 0));
        door_closed = 1'b1;
        cyc(1);
        start_pulse();
        cyc(99);
        check("t1_pre_tick", dut_out(), mk(3, 5, 9, 1));
        cyc(1);
        check("t1_first_tick", dut_out(), mk(3, 5, 8, 1));
        finish_cook("t1_total", 100, 239 * TPS);

        // 2: door opened mid-cook
        enter3(2, 4, 5);
        start_pulse();
        cyc(300);
        check("t2_3s", dut_out(), mk(2, 4, 2, 1));
        door_closed = 1'b0;
        cyc(1);
        check("t2_paused", dut_out(), mk(2, 4, 2, 0));
        cyc(37);
        startn = 1'b0;
        cyc(3);
        startn = 1'b1;
        check("t2_start_open", dut_out(), mk(2, 4, 2, 0));
        door_closed = 1'b1;
        cyc(5);
        check("t2_closed_idle", dut_out(), mk(2, 4, 2, 0));
        start_pulse();
        finish_cook("t2_resume", 0, 162 * TPS);

        // 3: stop button, with start held during stop
        enter3(2, 4, 5);
        start_pulse();
        cyc(300);
        stopn = 1'b0;
        cyc(1);
        check("t3_paused", dut_out(), mk(2, 4, 2, 0));
        startn = 1'b0;
        cyc(5);
        check("t3_stop_holds", dut_out(), mk(2, 4, 2, 0));
        startn = 1'b1;
        stopn  = 1'b1;
        cyc(2);
        start_pulse();
        finish_cook("t3_resume", 0, 162 * TPS);

        // 4: clear mid-cook, then start with zero time
        enter3(2, 4, 5);
        start_pulse();
        cyc(300);
        check("t4_3s", dut_out(), mk(2, 4, 2, 1));
        do_clear();
        start_pulse();
        cyc(5);
        check("t4_zero_start", dut_out(), mk(0, 0, 0, 0));

        // 5: non-normalised seconds-tens
        enter3(1, 7, 9);
        check("t5_entry", dut_out(), mk(1, 7, 9, 0));
        start_pulse();
        cyc(1000);
        check("t5_10s", dut_out(), mk(1, 6, 9, 1));
        cyc(7000);
        check("t5_80s", dut_out(), mk(0, 5, 9, 1));
        finish_cook("t5_total", 8000, 139 * TPS);

        // 6: held key, multi-key priority, keys during cook
        press(4, 11);
        check("t6_held", dut_out(), mk(0, 0, 4, 0));
        press(1, 1);
        check("t6_second", dut_out(), mk(0, 4, 1, 0));
        start_pulse();
        cyc(3);
        press(7, 2);
        check("t6_cook_key", dut_out(), mk(0, 4, 1, 1));
        do_clear();
        keypad = 10'b0000100100;
        cyc(2);
        keypad = 10'd0;
        cyc(1);
        check("t6_multi", dut_out(), mk(0, 0, 5, 0));

        // random panel activity
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 15)      keypad = 10'(1 << $urandom_range(0, 9));
            else if (r < 20) keypad = 10'($urandom_range(1, 1023));
            else             keypad = 10'd0;
            startn      = ($urandom_range(0, 7) != 0);
            stopn       = ($urandom_range(0, 15) != 0);
            door_closed = ($urandom_range(0, 15) != 0);
            if (r == 99) do_clear();
            cyc($urandom_range(1, 20));
        end

        keypad = 10'd0; startn = 1'b1; stopn = 1'b1; door_closed = 1'b1;
        do_clear();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
